// File: rtl/readout_rx_pkg.sv
// rtl/readout_rx_pkg.sv - shared defaults and result entry type for the readout RX decision stage
package readout_rx_pkg;

  localparam int RX_NUM_QUBITS = 8;
  localparam int RX_SCORE_W    = 16;
  localparam int RX_FIFO_DEPTH = 4;
  localparam int RX_TS_W       = 16;
  localparam int RX_QID_W      = $clog2(RX_NUM_QUBITS);
  localparam int RX_LEVEL_W    = $clog2(RX_FIFO_DEPTH) + 1;

  // One decision as seen by the downstream aggregator (default channel count)
  typedef struct packed {
    logic [RX_QID_W-1:0] qid;
    logic                result;
`ifdef READOUT_RX_DECISION_TIMESTAMP_EN
    logic [RX_TS_W-1:0]  ts;
`endif
  } decision_entry_t;

endpackage

// File: rtl/readout_rx_result_fifo.sv
// rtl/readout_rx_result_fifo.sv - small registered-output result FIFO (power-of-two depth)
module readout_rx_result_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head comes straight from storage flops; forced to zero while empty
  assign head    = empty ? '0 : mem[rd_ptr];

  // Entry storage; no reset needed since level gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/readout_rx_state_decision_output_multi.sv
// rtl/readout_rx_state_decision_output_multi.sv - per-qubit threshold decisions, round-robin into result FIFO; option READOUT_RX_DECISION_TIMESTAMP_EN
module readout_rx_state_decision_output_multi
  import readout_rx_pkg::*;
#(
  parameter int NUM_QUBITS = RX_NUM_QUBITS,
  parameter int SCORE_W    = RX_SCORE_W,
  parameter int FIFO_DEPTH = RX_FIFO_DEPTH,
  parameter int QID_W      = $clog2(NUM_QUBITS)
`ifdef READOUT_RX_DECISION_TIMESTAMP_EN
  , parameter int TS_W     = RX_TS_W
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_QUBITS-1:0]         finish_count_in,
  input  logic [NUM_QUBITS*SCORE_W-1:0] score_in,
  input  logic                          thr_wr_en,
  input  logic [QID_W-1:0]              thr_wr_idx,
  input  logic [SCORE_W-1:0]            thr_wr_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [QID_W-1:0]              out_qid,
  output logic                          out_result,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
`ifdef READOUT_RX_DECISION_TIMESTAMP_EN
  output logic [TS_W-1:0]               out_ts,
`endif
  output logic                          overflow
);

`ifdef READOUT_RX_DECISION_TIMESTAMP_EN
  localparam int ENTRY_W = QID_W + 1 + TS_W;
`else
  localparam int ENTRY_W = QID_W + 1;
`endif

  logic signed [SCORE_W-1:0] thr [NUM_QUBITS];
  logic [NUM_QUBITS-1:0]     result;
  logic [NUM_QUBITS-1:0]     pending;
  logic [NUM_QUBITS-1:0]     res;
  logic [QID_W-1:0]          rr_ptr;
  logic                      grant_valid;
  logic [QID_W-1:0]          grant_idx;
  logic                      fifo_full;
  logic [ENTRY_W-1:0]        push_data;
  logic [ENTRY_W-1:0]        head;

  // Strict signed comparison against the currently stored threshold
  always_comb begin
    result = '0;
    for (int i = 0; i < NUM_QUBITS; i++) begin
      result[i] = $signed(score_in[i*SCORE_W +: SCORE_W]) > thr[i];
    end
  end

  // Round-robin search starting at rr_ptr; stalls entirely while the FIFO is full
  always_comb begin
    int               j;
    logic [QID_W-1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    j           = 0;
    cand        = '0;
    if (!fifo_full) begin
      for (int k = 0; k < NUM_QUBITS; k++) begin
        j    = (int'(rr_ptr) + k) % NUM_QUBITS;
        cand = QID_W'(j);
        if (!grant_valid && pending[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  // Thresholds, pending/result capture, overwrite detection and pointer advance
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      res      <= '0;
      overflow <= 1'b0;
      rr_ptr   <= '0;
      for (int i = 0; i < NUM_QUBITS; i++) thr[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_QUBITS; i++) begin
        if (thr_wr_en && thr_wr_idx == QID_W'(i)) thr[i] <= thr_wr_data;
        if (finish_count_in[i]) begin
          // A grant this cycle ships the old result, so only an ungranted overwrite loses data
          pending[i] <= 1'b1;
          res[i]     <= result[i];
          if (pending[i] && !(grant_valid && grant_idx == QID_W'(i))) overflow <= 1'b1;
        end else if (grant_valid && grant_idx == QID_W'(i)) begin
          pending[i] <= 1'b0;
        end
      end
      if (grant_valid) begin
        rr_ptr <= (grant_idx == QID_W'(NUM_QUBITS - 1)) ? '0 : grant_idx + QID_W'(1);
      end
    end
  end

`ifdef READOUT_RX_DECISION_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_reg [NUM_QUBITS];

  // Free-running cycle counter, latched per channel at capture time
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt <= '0;
      for (int i = 0; i < NUM_QUBITS; i++) ts_reg[i] <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
      for (int i = 0; i < NUM_QUBITS; i++) begin
        if (finish_count_in[i]) ts_reg[i] <= ts_cnt;
      end
    end
  end

  assign push_data = {grant_idx, res[grant_idx], ts_reg[grant_idx]};
  assign out_ts    = head[TS_W-1:0];
`else
  assign push_data = {grant_idx, res[grant_idx]};
`endif

  assign out_qid    = head[ENTRY_W-1 -: QID_W];
  assign out_result = head[ENTRY_W-1-QID_W];
  assign out_valid  = (fifo_level != '0);

  readout_rx_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant_valid),
    .push_data (push_data),
    .pop       (out_valid && out_ready),
    .head      (head),
    .level     (fifo_level),
    .full      (fifo_full)
  );

endmodule
